// File: rtl/alu_exec_if.sv
// alu_exec_if
//   Groups the request and response handshakes of the ALU execute unit.
//   master : the side that issues ops and consumes results (e.g. the decode stage / bench)
//   slave  : the execute unit itself
//   Request : in_valid, in_ready, ALUControl, src_a, src_b, shamt
//   Response: out_valid, out_ready, result, zero, overflow, illegal, busy
interface alu_exec_if #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
);
    logic               in_valid;
    logic               in_ready;
    logic [3:0]         ALUControl;
    logic [WIDTH-1:0]   src_a;
    logic [WIDTH-1:0]   src_b;
    logic [SHAMT_W-1:0] shamt;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   result;
    logic               zero;
    logic               overflow;
    logic               illegal;
    logic               busy;

    modport master (
        output in_valid, ALUControl, src_a, src_b, shamt, out_ready,
        input  in_ready, out_valid, result, zero, overflow, illegal, busy
    );

    modport slave (
        input  in_valid, ALUControl, src_a, src_b, shamt, out_ready,
        output in_ready, out_valid, result, zero, overflow, illegal, busy
    );
endinterface

// File: rtl/alu_exec_unit.sv
// alu_exec_unit
//   Execute stage behind the ALU control decoder. Logic/arithmetic ops complete
//   in one cycle; shifts run on a 1-bit-per-cycle shifter (latency 1 + shamt).
//   Result, zero, overflow and illegal are registered and held until out_ready.
// Ports
//   clk    : rising-edge clock
//   rst_n  : synchronous, active-low reset
//   bus    : alu_exec_if.slave (request/response handshakes, result and flags)
module alu_exec_unit #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic       clk,
    input  logic       rst_n,
    alu_exec_if.slave  bus
);
    localparam logic [3:0] OP_PASS = 4'b0000;
    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SLL  = 4'b0011;
    localparam logic [3:0] OP_SRL  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_AND  = 4'b1010;
    localparam logic [3:0] OP_OR   = 4'b1011;
    localparam logic [3:0] OP_XOR  = 4'b1100;
    localparam logic [3:0] OP_NOR  = 4'b1101;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t state, state_d;

    // Signed overflow: operands agree in sign (ADD) or differ (SUB), and the result sign flips.
    function automatic logic add_ovf(input logic sa, input logic sb, input logic sr);
        return (sa == sb) && (sr != sa);
    endfunction

    function automatic logic sub_ovf(input logic sa, input logic sb, input logic sr);
        return (sa != sb) && (sr != sa);
    endfunction

    function automatic logic signed [WIDTH-1:0] shift1(input logic [3:0] op,
                                                       input logic signed [WIDTH-1:0] w);
        case (op)
            OP_SLL:  return w <<< 1;
            OP_SRA:  return w >>> 1;
            default: return {1'b0, w[WIDTH-1:1]};
        endcase
    endfunction

    logic signed [WIDTH-1:0] a_s, b_s, alu_res;
    logic                    alu_ovf, alu_ill, is_shift;

    // captured shift op, working operand and remaining count
    logic [3:0]              sop_p0;
    logic signed [WIDTH-1:0] work_p0, work_nxt;
    logic [SHAMT_W-1:0]      cnt_p0;

    // registered outputs
    logic [WIDTH-1:0]        result_p1;
    logic                    zero_p1, ovf_p1, ill_p1;

    assign a_s      = bus.src_a;
    assign b_s      = bus.src_b;
    assign is_shift = (bus.ALUControl == OP_SLL) || (bus.ALUControl == OP_SRL) ||
                      (bus.ALUControl == OP_SRA);
    assign work_nxt = shift1(sop_p0, work_p0);

    always_comb begin
        alu_res = '0;
        alu_ovf = 1'b0;
        alu_ill = 1'b0;
        case (bus.ALUControl)
            OP_ADD: begin
                alu_res = a_s + b_s;
                alu_ovf = add_ovf(a_s[WIDTH-1], b_s[WIDTH-1], alu_res[WIDTH-1]);
            end
            OP_SUB: begin
                alu_res = a_s - b_s;
                alu_ovf = sub_ovf(a_s[WIDTH-1], b_s[WIDTH-1], alu_res[WIDTH-1]);
            end
            OP_AND:  alu_res = a_s & b_s;
            OP_OR:   alu_res = a_s | b_s;
            OP_XOR:  alu_res = a_s ^ b_s;
            OP_NOR:  alu_res = ~(a_s | b_s);
            OP_SLT:  alu_res = (a_s < b_s) ? WIDTH'(1) : '0;
            // shifts only reach this path with shamt == 0, where the result is b unchanged
            OP_SLL, OP_SRL, OP_SRA, OP_PASS: alu_res = b_s;
            default: alu_ill = 1'b1;
        endcase
    end

    always_comb begin
        state_d = state;
        case (state)
            IDLE:    if (bus.in_valid)
                         state_d = (is_shift && bus.shamt != '0) ? SHIFT : DONE;
            SHIFT:   if (cnt_p0 == SHAMT_W'(1)) state_d = DONE;
            DONE:    if (bus.out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // stage p0: op capture and iterative shift; stage p1: registered result and flags
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            result_p1 <= '0;
            zero_p1   <= 1'b0;
            ovf_p1    <= 1'b0;
            ill_p1    <= 1'b0;
        end else begin
            state <= state_d;
            case (state)
                IDLE: if (bus.in_valid) begin
                    if (is_shift && bus.shamt != '0) begin
                        sop_p0  <= bus.ALUControl;
                        work_p0 <= b_s;
                        cnt_p0  <= bus.shamt;
                    end else begin
                        result_p1 <= alu_res;
                        zero_p1   <= (alu_res == '0);
                        ovf_p1    <= alu_ovf;
                        ill_p1    <= alu_ill;
                    end
                end
                SHIFT: begin
                    work_p0 <= work_nxt;
                    cnt_p0  <= cnt_p0 - SHAMT_W'(1);
                    if (cnt_p0 == SHAMT_W'(1)) begin
                        result_p1 <= work_nxt;
                        zero_p1   <= (work_nxt == '0);
                        ovf_p1    <= 1'b0;
                        ill_p1    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready  = rst_n && (state == IDLE);
    assign bus.out_valid = (state == DONE);
    assign bus.busy      = (state != IDLE);
    assign bus.result    = result_p1;
    assign bus.zero      = zero_p1;
    assign bus.overflow  = ovf_p1;
    assign bus.illegal   = ill_p1;
endmodule
